// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/debug data-RAM arbiter: FSM states, grant encoding
// and RAM access-mode constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } gnt_t;

  localparam logic [1:0] MODE_BYTE = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_WORD = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (CPU load/store, debug read-only) arbiter onto a single synchronous data RAM.
// Optional conflict statistics counter enabled by defining MEM_ARB_STAT_EN.
//
// state  | meaning
// IDLE   | wait for a request; latch the round-robin winner's access
// ACCESS | drive the latched access onto the RAM port
// RESP   | RAM data valid; ack the winner and forward ram_rdata
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        cpu_mode,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_mode,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [31:0]       conflict_cnt
);

  state_t            state_q, state_d;
  gnt_t              gnt_sel_q, last_gnt_q, winner;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic [1:0]        lat_mode_q;
  logic              lat_we_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              take;

  // Round-robin: on a tie the requester that did not win last time goes first.
  always_comb begin
    winner = GNT_CPU;
    if (cpu_req && dbg_req) begin
      winner = (last_gnt_q == GNT_CPU) ? GNT_DBG : GNT_CPU;
    end else if (dbg_req) begin
      winner = GNT_DBG;
    end
  end

  assign take = (state_q == IDLE) && (cpu_req || dbg_req);

  always_comb begin
    state_d = state_q;
    cpu_ack = 1'b0;
    dbg_ack = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) state_d = ACCESS;
      end
      ACCESS: begin
        ram_we  = lat_we_q && (gnt_sel_q == GNT_CPU) && !clr;
        state_d = RESP;
      end
      RESP: begin
        cpu_ack = (gnt_sel_q == GNT_CPU) && !clr;
        dbg_ack = (gnt_sel_q == GNT_DBG) && !clr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      gnt_sel_q   <= GNT_CPU;
      last_gnt_q  <= GNT_DBG;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_mode_q  <= '0;
      lat_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        gnt_sel_q  <= winner;
        last_gnt_q <= winner;
        if (winner == GNT_CPU) begin
          lat_addr_q  <= cpu_addr;
          lat_wdata_q <= cpu_wdata;
          lat_mode_q  <= cpu_mode;
          lat_we_q    <= cpu_we;
        end else begin
          // Debug accesses are always whole-word reads.
          lat_addr_q  <= dbg_addr;
          lat_wdata_q <= '0;
          lat_mode_q  <= MODE_WORD;
          lat_we_q    <= 1'b0;
        end
      end
      if (cpu_ack) cpu_rdata_q <= ram_rdata;
      if (dbg_ack) dbg_rdata_q <= ram_rdata;
    end
  end

  assign ram_addr  = lat_addr_q;
  assign ram_wdata = lat_wdata_q;
  assign ram_mode  = lat_mode_q;

  assign cpu_rdata = cpu_ack ? ram_rdata : cpu_rdata_q;
  assign dbg_rdata = dbg_ack ? ram_rdata : dbg_rdata_q;
  assign cpu_stall = cpu_req && !cpu_ack;

`ifdef MEM_ARB_STAT_EN
  logic [31:0] conflict_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      conflict_q <= '0;
    end else if (cpu_req && dbg_req && !(cpu_ack || dbg_ack)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected acks into
// per-port queues, a negedge monitor pops and compares whenever an ack appears.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
`ifdef MEM_ARB_STAT_EN
  localparam int STAT_ON = 1;
`else
  localparam int STAT_ON = 0;
`endif

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [1:0]        cpu_mode = MODE_WORD;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;
  logic              dbg_req = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [1:0]        ram_mode;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [31:0]       conflict_cnt;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .clr(clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_mode(cpu_mode), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mode(ram_mode), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // RAM model: word i starts as 0xA500_0000 | i; read-before-write, 1-cycle latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA500_0000 | i;
      mem_init = 1'b1;
    end
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dbg_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (cpu_ack && dbg_ack) begin
      n_total++;
      $display("FAIL both_acks: cpu_ack and dbg_ack both high at cycle %0d", cyc);
    end
    if (cpu_ack) begin
      if (cpu_q.size() == 0) begin
        n_total++;
        $display("FAIL cpu_ack_unexpected: got ack at cycle %0d, expected none", cyc);
      end else begin
        mon_e = cpu_q.pop_front();
        check("cpu_ack_cycle", cyc, mon_e.cyc);
        check("cpu_rdata", cpu_rdata, mon_e.data);
      end
    end
    if (dbg_ack) begin
      if (dbg_q.size() == 0) begin
        n_total++;
        $display("FAIL dbg_ack_unexpected: got ack at cycle %0d, expected none", cyc);
      end else begin
        mon_e = dbg_q.pop_front();
        check("dbg_ack_cycle", cyc, mon_e.cyc);
        check("dbg_rdata", dbg_rdata, mon_e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Callers start just after a posedge with the FSM idle.
  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata);
    bit got = 1'b0;
    int n0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_mode = MODE_WORD;
    n0 = cyc;
    cpu_q.push_back('{n0 + 2, exp_rdata});
    @(negedge clk);
    check("stall_n", cpu_stall, 1'b1);
    check("ram_we_n", ram_we, 1'b0);
    step();
    @(negedge clk);
    check("stall_n1", cpu_stall, 1'b1);
    check("ram_we_n1", ram_we, we);
    check("ram_addr_n1", ram_addr, addr);
    check("ram_mode_n1", ram_mode, MODE_WORD);
    if (we) check("ram_wdata_n1", ram_wdata, wdata);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack) got = 1'b1;
    end
    if (!got) fail_timeout("cpu_ack_wait");
    check("stall_ack", cpu_stall, 1'b0);
    check("ram_we_ack", ram_we, 1'b0);
    step();
    cpu_req = 1'b0;
  endtask

  task automatic dbg_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp_rdata);
    bit got = 1'b0;
    dbg_req = 1'b1; dbg_addr = addr;
    dbg_q.push_back('{cyc + 2, exp_rdata});
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      check("dbg_ram_we", ram_we, 1'b0);
      if (dbg_ack) got = 1'b1;
    end
    if (!got) fail_timeout("dbg_ack_wait");
    step();
    dbg_req = 1'b0;
  endtask

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_dbg_ack", dbg_ack, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, '0);
    check("rst_cpu_rdata", cpu_rdata, '0);
    check("rst_dbg_rdata", dbg_rdata, '0);
    check("rst_conflict", conflict_cnt, '0);

    // Tie right after reset: CPU first, then alternation while both stay high.
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h004;
    dbg_req = 1'b1; dbg_addr = 12'h008;
    n0 = cyc;
    cpu_q.push_back('{n0 + 2, 32'hA500_0004});
    cpu_q.push_back('{n0 + 8, 32'hA500_0004});
    dbg_q.push_back('{n0 + 5, 32'hA500_0008});
    dbg_q.push_back('{n0 + 11, 32'hA500_0008});
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("conflict_held", conflict_cnt, STAT_ON ? 32'd8 : 32'd0);
    step();
    cpu_req = 1'b0; dbg_req = 1'b0;
    step();
    @(negedge clk);
    check("conflict_after", conflict_cnt, STAT_ON ? 32'd8 : 32'd0);
    step();

    cpu_access(1'b1, 12'h010, 32'hDEAD_BEEF, 32'hA500_0010);
    cpu_access(1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF);

    // Write-like CPU signals while only debug requests.
    cpu_we = 1'b1; cpu_wdata = 32'h5555_AAAA;
    dbg_read(12'h010, 32'hDEAD_BEEF);
    @(negedge clk);
    check("cpu_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
    check("dbg_rdata_hold", dbg_rdata, 32'hDEAD_BEEF);
    step();

    // clr during ACCESS of a CPU write: abandoned, no write, no ack.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    step();
    clr = 1'b1;
    @(negedge clk);
    check("clr_ram_we", ram_we, 1'b0);
    check("clr_cpu_ack", cpu_ack, 1'b0);
    step();
    clr = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("post_clr_ack", cpu_ack, 1'b0);
    check("post_clr_cpu_rdata", cpu_rdata, '0);
    check("post_clr_dbg_rdata", dbg_rdata, '0);
    dbg_read(12'h020, 32'hA500_0020);

    repeat (4) step();
    check("cpu_q_empty", cpu_q.size(), 32'd0);
    check("dbg_q_empty", dbg_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, data-RAM word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 clr  in  1  reset, synchronous, active-high.
REQ-005 cpu_req  in  1  CPU load/store request, held until cpu_ack.
REQ-006 cpu_we  in  1  CPU write (1) / read (0).
REQ-007 cpu_addr  in  ADDR_W  CPU address (ALU result low bits).
REQ-008 cpu_wdata  in  DATA_W  CPU store data.
REQ-009 cpu_mode  in  2  byte/half/word access mode, passed to RAM unchanged.
REQ-010 cpu_rdata  out  DATA_W  CPU load data, valid when cpu_ack=1.
REQ-011 cpu_ack  out  1  one-cycle completion pulse for the CPU.
REQ-012 cpu_stall  out  1  PC/regfile hold: cpu_req & ~cpu_ack, combinational.
REQ-013 dbg_req  in  1  debug/display read request, held until dbg_ack.
REQ-014 dbg_addr  in  ADDR_W  debug read address.
REQ-015 dbg_rdata  out  DATA_W  debug read data, valid when dbg_ack=1.
REQ-016 dbg_ack  out  1  one-cycle completion pulse for the debug port.
REQ-017 ram_addr / ram_wdata / ram_mode / ram_we  out  ADDR_W/DATA_W/2/1  RAM port drive.
REQ-018 ram_rdata  in  DATA_W  RAM read data, one-cycle synchronous latency.
REQ-019 conflict_cnt  out  32  count of cycles in which both requests were pending (see Configuration).

Function
REQ-020 FSM states IDLE, ACCESS, RESP; exactly one access in flight.
REQ-021 IDLE: no request -> stay; any request -> latch the winner's addr/we/wdata/mode, record the winner in gnt_sel, go to ACCESS.
REQ-022 Arbitration: single requester wins; both pending -> the requester not in last_gnt wins (round-robin).
REQ-023 last_gnt updates to the winner on the IDLE->ACCESS transition.
REQ-024 ACCESS: ram_* driven from latched values; ram_we = latched we & gnt_sel==CPU & ~clr; -> RESP.
REQ-025 RESP: winner's ack=1 and its rdata = ram_rdata; other ack=0; -> IDLE unconditionally.
REQ-026 Latency: request first seen in IDLE at cycle N -> ack in cycle N+2; throughput one access per 3 cycles.
REQ-027 Debug port is read-only; ram_we is never 1 for a debug grant.
REQ-028 Outside ACCESS: ram_we=0; ram_addr/ram_wdata/ram_mode hold their latched values.
REQ-029 cpu_rdata/dbg_rdata hold their last acked values between acks.
REQ-030 A requester whose req drops before its grant is not serviced; a request that drops after its grant still completes and acks.
REQ-031 A requester keeping req high in the cycle after its ack is treated as a new request.

Reset
REQ-032 clr=1 at a clock edge: state<=IDLE, last_gnt<=DBG (CPU wins the first tie), latched regs<=0, rdata outputs<=0, conflict_cnt<=0.
REQ-033 During clr: cpu_ack=dbg_ack=0, ram_we=0; an access in flight is abandoned without ack, and no RAM write occurs.

Configuration
REQ-034 Macro MEM_ARB_STAT_EN defined: conflict_cnt increments by 1, wrapping 0xFFFFFFFF->0, each non-reset cycle with cpu_req & dbg_req & ~(cpu_ack|dbg_ack).
REQ-035 Macro MEM_ARB_STAT_EN undefined: conflict_cnt is constant 0, no counter register exists, and the port remains.

Structure
REQ-036 Shared package mem_arb_pkg holds the state enum (IDLE/ACCESS/RESP), the grant-select encoding (CPU=0, DBG=1) and the mode constants (MODE_BYTE, MODE_HALF, MODE_WORD).
REQ-037 Single module; the round-robin pick is inline logic, with no sub-module.

Verification
REQ-038 Reset, then CPU write addr 0x010, data 0xDEADBEEF, mode word -> ram_we=1 one cycle at ram_addr 0x010, cpu_ack at N+2, cpu_stall high cycles N..N+1.
REQ-039 CPU read 0x010 after the write -> cpu_rdata=0xDEADBEEF with cpu_ack at N+2; dbg_ack stays 0.
REQ-040 Both requests raised in the same cycle after reset (CPU 0x004, DBG 0x008) -> CPU acked at N+2, DBG acked at N+5; with both held continuously, grants alternate DBG, CPU, DBG.
REQ-041 dbg_req with a write-like stimulus (cpu_we=1, CPU idle) -> ram_we never 1; dbg_rdata = RAM content.
REQ-042 clr asserted during ACCESS of a CPU write to 0x020 -> no ack, ram_we=0, RAM[0x020] unchanged, FSM in IDLE next cycle.
REQ-043 MEM_ARB_STAT_EN defined, both requests held for 6 cycles -> conflict_cnt equals the count of both-pending non-ack cycles; undefined -> stays 0.
